run_controller: RTL

- Host-side initiator for the core's start/halt run protocol; the core (top_level) is the responder.
- Launches a selected program by holding core_start high for a fixed number of cycles, then waits for core_halt.
- Reports the execution cycle count, or a timeout if the program never halts.
- Sits above top_level in the emulation harness, so programs run back-to-back without hand-written stimulus.

---
 rtl/run_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// rtl/run_controller.sv - host-side start/halt run initiator for the core
// Pulses core_start, counts RUN cycles until core_halt, and flags a timeout.
module run_controller #(
  parameter int START_CYCLES = 2,
  parameter int COUNT_W      = 16,
  parameter int PROG_W       = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               go_i,
  input  logic [PROG_W-1:0]  prog_sel_i,
  input  logic [COUNT_W-1:0] timeout_limit_i,
  input  logic               core_halt_i,
  output logic               core_start_o,
  output logic [PROG_W-1:0]  prog_id_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timed_out_o,
  output logic [COUNT_W-1:0] cycle_count_o
);

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [SC_W-1:0]    start_cnt_q, start_cnt_d;
  logic [COUNT_W-1:0] limit_q, limit_d;
  logic [COUNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [PROG_W-1:0]  prog_id_q, prog_id_d;
  logic               core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;

  // Outputs are computed as next-state values so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    start_cnt_d   = start_cnt_q;
    limit_d       = limit_q;
    cycle_count_d = cycle_count_q;
    prog_id_d     = prog_id_q;
    core_start_d  = core_start_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    timed_out_d   = timed_out_q;

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          prog_id_d     = prog_sel_i;
          limit_d       = timeout_limit_i;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
          start_cnt_d   = '0;
          core_start_d  = 1'b1;
          busy_d        = 1'b1;
          state_d       = S_START;
        end
      end
      S_START: begin
        // core_halt is meaningless while the core is held in start/reset.
        if (start_cnt_q == SC_LAST) begin
          core_start_d = 1'b0;
          state_d      = S_RUN;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (core_halt_i) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if ((limit_q != '0) && (cycle_count_q == limit_q)) begin
          timed_out_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_TIMEOUT;
        end else if (!(&cycle_count_q)) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_TIMEOUT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      start_cnt_q   <= '0;
      limit_q       <= '0;
      cycle_count_q <= '0;
      prog_id_q     <= '0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      limit_q       <= limit_d;
      cycle_count_q <= cycle_count_d;
      prog_id_q     <= prog_id_d;
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign core_start_o  = core_start_q;
  assign prog_id_o     = prog_id_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timed_out_o   = timed_out_q;
  assign cycle_count_o = cycle_count_q;

endmodule
